// File: rtl/cache_arbiter_if.sv
// Bus bundle between the I/D cache miss paths, the arbiter and the cacheline adaptor.
// The slave modport is the arbiter's view; master is the cache/memory environment.
interface cache_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_read, i_addr,
        output i_rdata, i_resp,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_addr, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output i_read, i_addr,
        input  i_rdata, i_resp,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_addr, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/cache_arbiter.sv
// Shares the physical-memory port between I-cache and D-cache, one line transaction at a time.
// CACHE_ARB_RR_EN: simultaneous I/D requests alternate against last_grant instead of D-first.
//
// state | meaning
// IDLE  | no memory request; arbitrate and latch the winner's request
// GNT_I | memory transaction in flight for the I-cache
// GNT_D | memory transaction in flight for the D-cache
// DONE  | one-cycle cooldown so the served cache can drop its request
module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    cache_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              last_d;
    logic              op_write;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              d_req;
    logic              grant_d;
    logic              grant_i;
    logic              busy;

    always_comb begin
        d_req = bus.d_read | bus.d_write;
`ifdef CACHE_ARB_RR_EN
        grant_d = d_req & (~bus.i_read | ~last_d);
`else
        grant_d = d_req;
`endif
        grant_i = bus.i_read & ~grant_d;
    end

`ifndef CACHE_ARB_RR_EN
    // last_grant is still tracked in the fixed-priority build but has no consumer.
    logic last_d_unused;
    assign last_d_unused = last_d;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d)      state_nxt = GNT_D;
                else if (grant_i) state_nxt = GNT_I;
            end
            GNT_I, GNT_D: begin
                if (bus.pmem_resp) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last_d   <= 1'b0;
            op_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (grant_d) begin
                    addr_q   <= bus.d_addr;
                    wdata_q  <= bus.d_wdata;
                    op_write <= bus.d_write;
                end else if (grant_i) begin
                    addr_q   <= bus.i_addr;
                    op_write <= 1'b0;
                end
            end
            if (busy && bus.pmem_resp) last_d <= (state == GNT_D);
        end
    end

    // Memory side sees only registered values, so requester changes mid-grant are invisible.
    assign busy           = (state == GNT_I) || (state == GNT_D);
    assign bus.pmem_read  = busy & ~op_write;
    assign bus.pmem_write = busy & op_write;
    assign bus.pmem_addr  = addr_q;
    assign bus.pmem_wdata = wdata_q;

    assign bus.i_resp  = (state == GNT_I) & bus.pmem_resp;
    assign bus.d_resp  = (state == GNT_D) & bus.pmem_resp;
    assign bus.i_rdata = bus.i_resp ? bus.pmem_rdata : '0;
    assign bus.d_rdata = bus.d_resp ? bus.pmem_rdata : '0;
endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory port (to the cacheline adaptor) between the I-cache miss path and the D-cache miss/writeback path.
- Sequences one line transaction at a time and latches the address and write data at grant.
- Routes the memory response back only to the granted cache.
- Sits below both caches; the hazard/stall logic sees its effect only through imem_resp and dmem_resp.

Parameters:
- LINE_W, 256, cacheline width in bits.
- ADDR_W, 32, physical address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- i_read  in  1  I-cache line read request.
- i_addr  in  ADDR_W  I-cache line address.
- i_rdata  out  LINE_W  line data to I-cache.
- i_resp  out  1  I-cache transaction complete.
- d_read  in  1  D-cache line read request.
- d_write  in  1  D-cache line writeback request.
- d_addr  in  ADDR_W  D-cache line address.
- d_wdata  in  LINE_W  D-cache writeback data.
- d_rdata  out  LINE_W  line data to D-cache.
- d_resp  out  1  D-cache transaction complete.
- pmem_read  out  1  memory line read.
- pmem_write  out  1  memory line write.
- pmem_addr  out  ADDR_W  memory address.
- pmem_wdata  out  LINE_W  memory write data.
- pmem_rdata  in  LINE_W  memory read data.
- pmem_resp  in  1  memory transaction complete.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; last_grant=I. All outputs 0, including the latched addr/wdata/op registers.
- Reset mid-transaction abandons the transaction; no resp is issued. The memory side is reset by the same signal.
- States:
  - IDLE: no pmem request driven.
  - GNT_I: serving the I-cache.
  - GNT_D: serving the D-cache.
  - DONE: one-cycle cooldown.
- IDLE transitions:
  - d_read|d_write asserted -> GNT_D. D wins any simultaneous I request (fixed priority).
  - else i_read -> GNT_I.
  - else stay in IDLE.
- On the IDLE->GNT_x edge, latch into registers:
  - address; for D also wdata.
  - op: read if d_read, write if d_write. d_read&d_write is illegal; write takes precedence.
- pmem outputs are driven only from the latched registers:
  - pmem_read/pmem_write are high every cycle in GNT_x until pmem_resp.
  - Request is seen in IDLE at cycle N; pmem_read/pmem_write are first high at N+1.
- Completion (pmem_resp=1 in GNT_x):
  - Same cycle, combinationally: x_resp=1 and x_rdata=pmem_rdata.
  - The other port's resp stays 0.
  - Next state DONE; last_grant=x.
- x_rdata is 0 whenever x_resp=0.
- DONE: no pmem request, no resp, no new grant. Always -> IDLE. This gives the cache one cycle to drop its request, so a just-satisfied request is never re-issued.
- Minimum spacing between back-to-back transactions: resp cycle M, next pmem request at M+3 (DONE M+1, IDLE M+2, GNT M+3).
- Requester drops its request mid-GNT: the transaction still completes (memory cannot abort) and resp is still pulsed to that port.
- Requester changes addr/wdata mid-GNT: no effect, because the values are latched.
- pmem_resp outside GNT_x: ignored; no resp is generated.
- No transaction is ever issued to memory while another is outstanding.
- pmem_read and pmem_write are never both high.

Optional Feature:
- Macro: CACHE_ARB_RR_EN.
- Defined: a simultaneous I and D request in IDLE is granted to the port opposite last_grant (round-robin). A lone request is granted immediately, as in the fixed-priority case.
- Undefined: fixed D-over-I priority as above; last_grant is still maintained but has no effect.

Test Plan:
- Lone I read: i_read=1, i_addr=0x0000_1000 in IDLE at cycle 0 -> pmem_read=1, pmem_addr=0x1000 from cycle 1. pmem_resp at cycle 5 with rdata=0xA5 pattern -> i_resp=1 and i_rdata=pattern in cycle 5 only; d_resp=0; IDLE at cycle 7.
- D writeback: d_write=1, d_addr=0x8000_0040, d_wdata=pattern B -> pmem_write=1, pmem_wdata=B, pmem_read=0 until pmem_resp -> single-cycle d_resp.
- Simultaneous i_read and d_read in IDLE, pmem_resp 3 cycles after each grant:
  - macro undefined: D served first, then I starts 3 cycles after D's resp.
  - CACHE_ARB_RR_EN with last_grant=D: I served first.
- Stability: change d_addr and d_wdata every cycle during GNT_D -> pmem_addr/pmem_wdata hold the grant-time values. A stray pmem_resp while IDLE or DONE -> no resp on either port.
- Reset mid-transaction: assert rst=0 during GNT_I with pmem_read=1 -> all outputs 0 immediately (asynchronous, before the next clk edge). After release, a pending d_read is granted first.
- Sustained contention (both caches requesting continuously, 200 transactions): no overlapping pmem requests, exactly one resp per pmem_resp. With CACHE_ARB_RR_EN, grants alternate I/D.
